coreriscv_axi4_tile_link_queued_enqueuer: RTL and testbench
===========================================================

Name: coreriscv_axi4_tile_link_queued_enqueuer

Overview:
- Parametrised successor to the zero-depth client TileLink enqueuer: inserts independently sized FIFOs on the acquire, release (inner->outer) and grant (outer->inner) channels.
- Probe and finish stay combinational pass-through.
- Sits between the L1 client port and the TileLink-to-AXI4 converter, decoupling core timing from the bus bridge.
- Channel payloads are packed vectors; field order is fixed below.

Parameters:
- DATA_W, 64, beat data width.
- ACQ_DEPTH, 2, acquire queue entries; 0 = wire pass-through.
- REL_DEPTH, 2, release queue entries; 0 = pass-through.
- GNT_DEPTH, 2, grant queue entries; 0 = pass-through.
- FLOW, 0, 1 = an empty queue forwards the inner beat in the same cycle (zero latency); 0 = minimum one-cycle latency.
- Derived widths: ACQ_W = 47+DATA_W; REL_W = 35+DATA_W; GNT_W = 12+DATA_W.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- io_inner_acquire_valid/ready  in/out  1  acquire handshake
- io_inner_acquire_bits  in  ACQ_W  {addr_block[25:0], client_xact_id[1:0], addr_beat[2:0], is_builtin_type, a_type[2:0], union[11:0], data}
- io_outer_acquire_valid/ready  out/in  1
- io_outer_acquire_bits  out  ACQ_W
- io_inner_release_valid/ready  in/out  1
- io_inner_release_bits  in  REL_W  {addr_beat[2:0], addr_block[25:0], client_xact_id[1:0], voluntary, r_type[2:0], data}
- io_outer_release_valid/ready  out/in  1
- io_outer_release_bits  out  REL_W
- io_outer_grant_valid/ready  in/out  1
- io_outer_grant_bits  in  GNT_W  {addr_beat[2:0], client_xact_id[1:0], manager_xact_id, is_builtin_type, g_type[3:0], manager_id, data}
- io_inner_grant_valid/ready  out/in  1
- io_inner_grant_bits  out  GNT_W
- io_outer_probe_valid/ready, io_inner_probe_valid/ready  in/out, out/in  1  pass-through
- io_outer_probe_bits / io_inner_probe_bits  in/out  28  {addr_block, p_type}
- io_inner_finish_valid/ready, io_outer_finish_valid/ready  in/out, out/in  1
- io_inner_finish_bits / io_outer_finish_bits  in/out  2  {manager_xact_id, manager_id}
- io_acq_count, io_rel_count, io_gnt_count  out  clog2(DEPTH+1) each  occupancy (debug)

Behaviour:
- Each queued channel is an identical instance: circular buffer with wr_ptr, rd_ptr (mod DEPTH, wrap DEPTH-1 -> 0) and count register.
- enq_ready = (count != DEPTH).
- deq_valid = (count != 0) || (FLOW && enq_valid).
- Enqueue fires when enq_valid && enq_ready; dequeue fires when deq_valid && deq_ready.
- Simultaneous enqueue and dequeue when full: dequeue frees the slot only next cycle; enq_ready stays low (no combinational ready path from outer to inner).
- Simultaneous enqueue and dequeue when 0 < count < DEPTH: count unchanged, both pointers advance.
- FLOW=1 with count==0:
  - outer bits = inner bits combinationally.
  - If deq_ready, the beat bypasses storage: no pointer or count change.
  - Otherwise the beat is written to the queue.
- FLOW=0 with count==0: a beat enqueued at cycle N appears on outer valid at N+1.
- Order is strictly FIFO. Multi-beat bursts (addr_beat 0..7) pass unaltered and are never reordered or interleaved within a channel.
- deq_bits = mem[rd_ptr], registered storage, no reset on the data array.
- DEPTH==0: channel is pure wires, ready/valid/bits identical to inputs; count output ties to 0.
- Probe and finish channels are always combinational wires.
- Reset (asserted low, asynchronous):
  - pointers and counts go to 0; all queued valids go 0 immediately.
  - in-flight contents are discarded.
  - enq_ready goes 1 for DEPTH>0.
  - Pass-through outputs follow their inputs even during reset.
- Deassertion is synchronous to clk via the existing reset synchroniser upstream.
- Throughput: one beat per cycle per channel when the outer side is always ready and DEPTH >= 2 (or DEPTH==1 with FLOW=1).
- Channels are fully independent; no cross-channel ordering is imposed.

Test Plan:
- Reset mid-burst: fill acquire with 2 beats, assert reset=0 -> io_outer_acquire_valid=0 and io_acq_count=0 in the same cycle; after release, io_inner_acquire_ready=1.
- Throughput: DEPTH=2, FLOW=0, push 8-beat release (addr_beat 0..7, data=beat*0x1111), outer ready=1 -> outer valid from cycle 1, 8 consecutive beats in order, count never exceeds 1.
- Backpressure full: outer grant ready=0, push 3 grants into GNT_DEPTH=2 -> third stalls (io_outer_grant_ready=0), io_gnt_count=2; raise ready -> beats emerge in order, third accepted one cycle after the first dequeue.
- FLOW=1 bypass: empty acquire, valid with addr_block=0x3ABCDEF, ready=1 -> outer valid and bits in the same cycle, count stays 0.
- DEPTH=0 equivalence: random traffic on all channels -> outputs bit-identical to inputs every cycle.
- Wrap-around: DEPTH=3, 10 enqueue/dequeue pairs at random stalls -> scoreboard match, pointers wrap 2->0 with no loss or duplication.

Source files
------------

// File: rtl/coreriscv_axi4_tile_link_queued_enqueuer.sv
// Queued TileLink client enqueuer.
// This block sits between the L1 client port and the TileLink-to-AXI4 converter.
// The acquire and release channels (inner->outer) and the grant channel
// (outer->inner) each pass through their own FIFO. Each FIFO depth is set
// separately. Probe and finish are combinational wires.
//
// Ports (top):
//   clk, reset                       clock, asynchronous active-low reset
//   io_{inner,outer}_acquire_*       acquire  inner -> outer, ACQ_W bits
//   io_{inner,outer}_release_*       release  inner -> outer, REL_W bits
//   io_{outer,inner}_grant_*         grant    outer -> inner, GNT_W bits
//   io_{outer,inner}_probe_*         probe    outer -> inner, 28 bits, wires
//   io_{inner,outer}_finish_*        finish   inner -> outer, 2 bits, wires
//   io_{acq,rel,gnt}_count           queue occupancy (debug)

// Single channel queue. It is a circular buffer with a separate occupancy counter.
// DEPTH == 0 turns the queue into plain wires.
module coreriscv_axi4_tile_link_queued_enqueuer_queue #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int FLOW  = 0,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enq_valid_i,
    output logic          enq_ready_o,
    input  logic [W-1:0]  enq_bits_i,
    output logic          deq_valid_o,
    input  logic          deq_ready_i,
    output logic [W-1:0]  deq_bits_o,
    output logic [CW-1:0] count_o
);
    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk & rst_n;
        assign enq_ready_o    = deq_ready_i;
        assign deq_valid_o    = enq_valid_i;
        assign deq_bits_o     = enq_bits_i;
        assign count_o        = '0;
    end else begin : g_fifo
        localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
        localparam logic [CW-1:0] FULL = CW'(DEPTH);
        localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

        logic [W-1:0]  mem_q [DEPTH];
        logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
        logic [CW-1:0] count_q, count_d;
        logic          empty, bypass, enq_fire, deq_fire;

        assign empty = (count_q == '0);
        // The ready signal depends only on the registered count. A dequeue on a full
        // queue therefore frees the slot in the next cycle. There is no
        // combinational path from the outer ready to the inner ready.
        assign enq_ready_o = (count_q != FULL);
        assign deq_valid_o = !empty || ((FLOW != 0) && enq_valid_i);
        assign deq_bits_o  = ((FLOW != 0) && empty) ? enq_bits_i : mem_q[rd_ptr_q];

        // In flow mode, a beat that arrives at an empty queue is taken directly
        // by the consumer. That beat does not touch the storage.
        assign bypass   = (FLOW != 0) && empty && enq_valid_i && deq_ready_i;
        assign enq_fire = enq_valid_i && enq_ready_o && !bypass;
        assign deq_fire = deq_ready_i && !empty;

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            if (enq_fire) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
            if (deq_fire) rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
            if (enq_fire && !deq_fire)      count_d = count_q + 1'b1;
            else if (!enq_fire && deq_fire) count_d = count_q - 1'b1;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
            end
        end

        // The data array has no reset. Reset drops its contents by clearing the count.
        always_ff @(posedge clk) begin
            if (enq_fire) mem_q[wr_ptr_q] <= enq_bits_i;
        end

        assign count_o = count_q;
    end
endmodule

module coreriscv_axi4_tile_link_queued_enqueuer #(
    parameter  int DATA_W    = 64,
    parameter  int ACQ_DEPTH = 2,
    parameter  int REL_DEPTH = 2,
    parameter  int GNT_DEPTH = 2,
    parameter  int FLOW      = 0,
    localparam int ACQ_W     = 47 + DATA_W,
    localparam int REL_W     = 35 + DATA_W,
    localparam int GNT_W     = 12 + DATA_W,
    localparam int ACQ_CW    = (ACQ_DEPTH > 0) ? $clog2(ACQ_DEPTH + 1) : 1,
    localparam int REL_CW    = (REL_DEPTH > 0) ? $clog2(REL_DEPTH + 1) : 1,
    localparam int GNT_CW    = (GNT_DEPTH > 0) ? $clog2(GNT_DEPTH + 1) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_inner_acquire_valid,
    output logic              io_inner_acquire_ready,
    input  logic [ACQ_W-1:0]  io_inner_acquire_bits,
    output logic              io_outer_acquire_valid,
    input  logic              io_outer_acquire_ready,
    output logic [ACQ_W-1:0]  io_outer_acquire_bits,
    input  logic              io_inner_release_valid,
    output logic              io_inner_release_ready,
    input  logic [REL_W-1:0]  io_inner_release_bits,
    output logic              io_outer_release_valid,
    input  logic              io_outer_release_ready,
    output logic [REL_W-1:0]  io_outer_release_bits,
    input  logic              io_outer_grant_valid,
    output logic              io_outer_grant_ready,
    input  logic [GNT_W-1:0]  io_outer_grant_bits,
    output logic              io_inner_grant_valid,
    input  logic              io_inner_grant_ready,
    output logic [GNT_W-1:0]  io_inner_grant_bits,
    input  logic              io_outer_probe_valid,
    output logic              io_outer_probe_ready,
    input  logic [27:0]       io_outer_probe_bits,
    output logic              io_inner_probe_valid,
    input  logic              io_inner_probe_ready,
    output logic [27:0]       io_inner_probe_bits,
    input  logic              io_inner_finish_valid,
    output logic              io_inner_finish_ready,
    input  logic [1:0]        io_inner_finish_bits,
    output logic              io_outer_finish_valid,
    input  logic              io_outer_finish_ready,
    output logic [1:0]        io_outer_finish_bits,
    output logic [ACQ_CW-1:0] io_acq_count,
    output logic [REL_CW-1:0] io_rel_count,
    output logic [GNT_CW-1:0] io_gnt_count
);
    coreriscv_axi4_tile_link_queued_enqueuer_queue #(
        .W(ACQ_W), .DEPTH(ACQ_DEPTH), .FLOW(FLOW), .CW(ACQ_CW)
    ) u_acq_q (
        .clk(clk), .rst_n(reset),
        .enq_valid_i(io_inner_acquire_valid), .enq_ready_o(io_inner_acquire_ready),
        .enq_bits_i(io_inner_acquire_bits),
        .deq_valid_o(io_outer_acquire_valid), .deq_ready_i(io_outer_acquire_ready),
        .deq_bits_o(io_outer_acquire_bits), .count_o(io_acq_count)
    );

    coreriscv_axi4_tile_link_queued_enqueuer_queue #(
        .W(REL_W), .DEPTH(REL_DEPTH), .FLOW(FLOW), .CW(REL_CW)
    ) u_rel_q (
        .clk(clk), .rst_n(reset),
        .enq_valid_i(io_inner_release_valid), .enq_ready_o(io_inner_release_ready),
        .enq_bits_i(io_inner_release_bits),
        .deq_valid_o(io_outer_release_valid), .deq_ready_i(io_outer_release_ready),
        .deq_bits_o(io_outer_release_bits), .count_o(io_rel_count)
    );

    coreriscv_axi4_tile_link_queued_enqueuer_queue #(
        .W(GNT_W), .DEPTH(GNT_DEPTH), .FLOW(FLOW), .CW(GNT_CW)
    ) u_gnt_q (
        .clk(clk), .rst_n(reset),
        .enq_valid_i(io_outer_grant_valid), .enq_ready_o(io_outer_grant_ready),
        .enq_bits_i(io_outer_grant_bits),
        .deq_valid_o(io_inner_grant_valid), .deq_ready_i(io_inner_grant_ready),
        .deq_bits_o(io_inner_grant_bits), .count_o(io_gnt_count)
    );

    assign io_inner_probe_valid  = io_outer_probe_valid;
    assign io_inner_probe_bits   = io_outer_probe_bits;
    assign io_outer_probe_ready  = io_inner_probe_ready;
    assign io_outer_finish_valid = io_inner_finish_valid;
    assign io_outer_finish_bits  = io_inner_finish_bits;
    assign io_inner_finish_ready = io_outer_finish_ready;
endmodule

// File: tb/tb_coreriscv_axi4_tile_link_queued_enqueuer.sv
// Testbench with three instances that share one set of input stimulus:
//   u_a: FLOW=0, acquire/release/grant depths 2/2/2
//   u_b: FLOW=1, acquire/release/grant depths 2/3/1
//   u_c: all depths 0 (pure wires)
// Each channel is checked every cycle against an ideal FIFO held in a queue.
module tb_coreriscv_axi4_tile_link_queued_enqueuer;
    localparam int DW = 16;
    localparam int AW = 47 + DW;
    localparam int RW = 35 + DW;
    localparam int GW = 12 + DW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          acq_iv, acq_or, rel_iv, rel_or, gnt_iv, gnt_or;
    logic [AW-1:0] acq_ib;
    logic [RW-1:0] rel_ib;
    logic [GW-1:0] gnt_ib;
    logic          prb_v, prb_r, fin_v, fin_r;
    logic [27:0]   prb_b;
    logic [1:0]    fin_b;

    logic          a_acq_ir, a_acq_ov, a_rel_ir, a_rel_ov, a_gnt_ir, a_gnt_ov;
    logic [AW-1:0] a_acq_ob;
    logic [RW-1:0] a_rel_ob;
    logic [GW-1:0] a_gnt_ob;
    logic          a_prb_v, a_prb_r, a_fin_v, a_fin_r;
    logic [27:0]   a_prb_b;
    logic [1:0]    a_fin_b;
    logic [1:0]    a_acq_cnt, a_rel_cnt, a_gnt_cnt;

    logic          b_acq_ir, b_acq_ov, b_rel_ir, b_rel_ov, b_gnt_ir, b_gnt_ov;
    logic [AW-1:0] b_acq_ob;
    logic [RW-1:0] b_rel_ob;
    logic [GW-1:0] b_gnt_ob;
    logic          b_prb_v, b_prb_r, b_fin_v, b_fin_r;
    logic [27:0]   b_prb_b;
    logic [1:0]    b_fin_b;
    logic [1:0]    b_acq_cnt, b_rel_cnt;
    logic [0:0]    b_gnt_cnt;

    logic          c_acq_ir, c_acq_ov, c_rel_ir, c_rel_ov, c_gnt_ir, c_gnt_ov;
    logic [AW-1:0] c_acq_ob;
    logic [RW-1:0] c_rel_ob;
    logic [GW-1:0] c_gnt_ob;
    logic          c_prb_v, c_prb_r, c_fin_v, c_fin_r;
    logic [27:0]   c_prb_b;
    logic [1:0]    c_fin_b;
    logic [0:0]    c_acq_cnt, c_rel_cnt, c_gnt_cnt;

    coreriscv_axi4_tile_link_queued_enqueuer #(
        .DATA_W(DW), .ACQ_DEPTH(2), .REL_DEPTH(2), .GNT_DEPTH(2), .FLOW(0)
    ) u_a (
        .clk(clk), .reset(reset),
        .io_inner_acquire_valid(acq_iv), .io_inner_acquire_ready(a_acq_ir), .io_inner_acquire_bits(acq_ib),
        .io_outer_acquire_valid(a_acq_ov), .io_outer_acquire_ready(acq_or), .io_outer_acquire_bits(a_acq_ob),
        .io_inner_release_valid(rel_iv), .io_inner_release_ready(a_rel_ir), .io_inner_release_bits(rel_ib),
        .io_outer_release_valid(a_rel_ov), .io_outer_release_ready(rel_or), .io_outer_release_bits(a_rel_ob),
        .io_outer_grant_valid(gnt_iv), .io_outer_grant_ready(a_gnt_ir), .io_outer_grant_bits(gnt_ib),
        .io_inner_grant_valid(a_gnt_ov), .io_inner_grant_ready(gnt_or), .io_inner_grant_bits(a_gnt_ob),
        .io_outer_probe_valid(prb_v), .io_outer_probe_ready(a_prb_r), .io_outer_probe_bits(prb_b),
        .io_inner_probe_valid(a_prb_v), .io_inner_probe_ready(prb_r), .io_inner_probe_bits(a_prb_b),
        .io_inner_finish_valid(fin_v), .io_inner_finish_ready(a_fin_r), .io_inner_finish_bits(fin_b),
        .io_outer_finish_valid(a_fin_v), .io_outer_finish_ready(fin_r), .io_outer_finish_bits(a_fin_b),
        .io_acq_count(a_acq_cnt), .io_rel_count(a_rel_cnt), .io_gnt_count(a_gnt_cnt)
    );

    coreriscv_axi4_tile_link_queued_enqueuer #(
        .DATA_W(DW), .ACQ_DEPTH(2), .REL_DEPTH(3), .GNT_DEPTH(1), .FLOW(1)
    ) u_b (
        .clk(clk), .reset(reset),
        .io_inner_acquire_valid(acq_iv), .io_inner_acquire_ready(b_acq_ir), .io_inner_acquire_bits(acq_ib),
        .io_outer_acquire_valid(b_acq_ov), .io_outer_acquire_ready(acq_or), .io_outer_acquire_bits(b_acq_ob),
        .io_inner_release_valid(rel_iv), .io_inner_release_ready(b_rel_ir), .io_inner_release_bits(rel_ib),
        .io_outer_release_valid(b_rel_ov), .io_outer_release_ready(rel_or), .io_outer_release_bits(b_rel_ob),
        .io_outer_grant_valid(gnt_iv), .io_outer_grant_ready(b_gnt_ir), .io_outer_grant_bits(gnt_ib),
        .io_inner_grant_valid(b_gnt_ov), .io_inner_grant_ready(gnt_or), .io_inner_grant_bits(b_gnt_ob),
        .io_outer_probe_valid(prb_v), .io_outer_probe_ready(b_prb_r), .io_outer_probe_bits(prb_b),
        .io_inner_probe_valid(b_prb_v), .io_inner_probe_ready(prb_r), .io_inner_probe_bits(b_prb_b),
        .io_inner_finish_valid(fin_v), .io_inner_finish_ready(b_fin_r), .io_inner_finish_bits(fin_b),
        .io_outer_finish_valid(b_fin_v), .io_outer_finish_ready(fin_r), .io_outer_finish_bits(b_fin_b),
        .io_acq_count(b_acq_cnt), .io_rel_count(b_rel_cnt), .io_gnt_count(b_gnt_cnt)
    );

    coreriscv_axi4_tile_link_queued_enqueuer #(
        .DATA_W(DW), .ACQ_DEPTH(0), .REL_DEPTH(0), .GNT_DEPTH(0), .FLOW(0)
    ) u_c (
        .clk(clk), .reset(reset),
        .io_inner_acquire_valid(acq_iv), .io_inner_acquire_ready(c_acq_ir), .io_inner_acquire_bits(acq_ib),
        .io_outer_acquire_valid(c_acq_ov), .io_outer_acquire_ready(acq_or), .io_outer_acquire_bits(c_acq_ob),
        .io_inner_release_valid(rel_iv), .io_inner_release_ready(c_rel_ir), .io_inner_release_bits(rel_ib),
        .io_outer_release_valid(c_rel_ov), .io_outer_release_ready(rel_or), .io_outer_release_bits(c_rel_ob),
        .io_outer_grant_valid(gnt_iv), .io_outer_grant_ready(c_gnt_ir), .io_outer_grant_bits(gnt_ib),
        .io_inner_grant_valid(c_gnt_ov), .io_inner_grant_ready(gnt_or), .io_inner_grant_bits(c_gnt_ob),
        .io_outer_probe_valid(prb_v), .io_outer_probe_ready(c_prb_r), .io_outer_probe_bits(prb_b),
        .io_inner_probe_valid(c_prb_v), .io_inner_probe_ready(prb_r), .io_inner_probe_bits(c_prb_b),
        .io_inner_finish_valid(fin_v), .io_inner_finish_ready(c_fin_r), .io_inner_finish_bits(fin_b),
        .io_outer_finish_valid(c_fin_v), .io_outer_finish_ready(fin_r), .io_outer_finish_bits(c_fin_b),
        .io_acq_count(c_acq_cnt), .io_rel_count(c_rel_cnt), .io_gnt_count(c_gnt_cnt)
    );

    // Reference: each channel is an ideal bounded FIFO of the beats it has accepted.
    logic [127:0] mq [9][$];
    int           dep [9];
    bit           flw [9];
    int           total = 0;
    int           bad   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check one channel against the ideal FIFO. Then advance the FIFO by the
    // handshakes that occur at the coming clock edge.
    task automatic chk_ch(input int k, input string tag, input logic iv, input logic [127:0] ib,
                          input logic ordy, input logic ir, input logic ov,
                          input logic [127:0] ob, input int cnt);
        int           sz;
        logic         e_ir, e_ov;
        logic [127:0] e_ob;
        int           e_cnt;
        sz = mq[k].size();
        if (dep[k] == 0) begin
            e_ir = ordy; e_ov = iv; e_ob = ib; e_cnt = 0;
        end else begin
            e_ir  = (sz < dep[k]);
            e_ov  = (sz > 0) || (flw[k] && iv);
            e_ob  = (sz > 0) ? mq[k][0] : ib;
            e_cnt = sz;
        end
        chk({tag, "_in_ready"}, 128'(ir), 128'(e_ir));
        chk({tag, "_out_valid"}, 128'(ov), 128'(e_ov));
        chk({tag, "_count"}, 128'(cnt), 128'(e_cnt));
        if (e_ov) chk({tag, "_out_bits"}, ob, e_ob);
        if (dep[k] != 0 && reset) begin
            if (!(sz == 0 && flw[k] && iv && ordy)) begin
                if (e_ov && ordy) void'(mq[k].pop_front());
                if (iv && e_ir) mq[k].push_back(ib);
            end
        end
    endtask

    task automatic chk_pt(input string tag, input logic pv, input logic [27:0] pb, input logic pr,
                          input logic fv, input logic [1:0] fb, input logic fr);
        chk({tag, "_probe_valid"}, 128'(pv), 128'(prb_v));
        chk({tag, "_probe_bits"}, 128'(pb), 128'(prb_b));
        chk({tag, "_probe_ready"}, 128'(pr), 128'(prb_r));
        chk({tag, "_finish_valid"}, 128'(fv), 128'(fin_v));
        chk({tag, "_finish_bits"}, 128'(fb), 128'(fin_b));
        chk({tag, "_finish_ready"}, 128'(fr), 128'(fin_r));
    endtask

    task automatic check_all();
        chk_ch(0, "a_acq", acq_iv, 128'(acq_ib), acq_or, a_acq_ir, a_acq_ov, 128'(a_acq_ob), int'(a_acq_cnt));
        chk_ch(1, "a_rel", rel_iv, 128'(rel_ib), rel_or, a_rel_ir, a_rel_ov, 128'(a_rel_ob), int'(a_rel_cnt));
        chk_ch(2, "a_gnt", gnt_iv, 128'(gnt_ib), gnt_or, a_gnt_ir, a_gnt_ov, 128'(a_gnt_ob), int'(a_gnt_cnt));
        chk_ch(3, "b_acq", acq_iv, 128'(acq_ib), acq_or, b_acq_ir, b_acq_ov, 128'(b_acq_ob), int'(b_acq_cnt));
        chk_ch(4, "b_rel", rel_iv, 128'(rel_ib), rel_or, b_rel_ir, b_rel_ov, 128'(b_rel_ob), int'(b_rel_cnt));
        chk_ch(5, "b_gnt", gnt_iv, 128'(gnt_ib), gnt_or, b_gnt_ir, b_gnt_ov, 128'(b_gnt_ob), int'(b_gnt_cnt));
        chk_ch(6, "c_acq", acq_iv, 128'(acq_ib), acq_or, c_acq_ir, c_acq_ov, 128'(c_acq_ob), int'(c_acq_cnt));
        chk_ch(7, "c_rel", rel_iv, 128'(rel_ib), rel_or, c_rel_ir, c_rel_ov, 128'(c_rel_ob), int'(c_rel_cnt));
        chk_ch(8, "c_gnt", gnt_iv, 128'(gnt_ib), gnt_or, c_gnt_ir, c_gnt_ov, 128'(c_gnt_ob), int'(c_gnt_cnt));
        chk_pt("a", a_prb_v, a_prb_b, a_prb_r, a_fin_v, a_fin_b, a_fin_r);
        chk_pt("b", b_prb_v, b_prb_b, b_prb_r, b_fin_v, b_fin_b, b_fin_r);
        chk_pt("c", c_prb_v, c_prb_b, c_prb_r, c_fin_v, c_fin_b, c_fin_r);
    endtask

    // One cycle: check on the falling edge, then let the rising edge happen.
    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 9; k++) mq[k].delete();
    endtask

    initial begin
        logic acc;
        int   n;
        dep = '{2, 2, 2, 2, 3, 1, 0, 0, 0};
        flw = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
        acq_iv = 0; acq_or = 0; acq_ib = '0;
        rel_iv = 0; rel_or = 0; rel_ib = '0;
        gnt_iv = 0; gnt_or = 0; gnt_ib = '0;
        prb_v = 0; prb_r = 0; prb_b = '0;
        fin_v = 0; fin_r = 0; fin_b = '0;

        // Reset state
        reset = 1'b1;
        #3 reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();

        // Reset in the middle of a burst
        acq_iv = 1; acq_ib = {26'h1234567, 2'd1, 3'd0, 1'b1, 3'd2, 12'h0AB, 16'hBEE0};
        step();
        acq_ib = {26'h1234567, 2'd1, 3'd1, 1'b1, 3'd2, 12'h0AB, 16'hBEE1};
        step();
        acq_iv = 0;
        step();
        chk("burst_acq_count", 128'(a_acq_cnt), 128'(2));
        reset = 1'b0;
        clear_model();
        #1;
        chk("rst_acq_valid", 128'(a_acq_ov), 128'(0));
        chk("rst_acq_count", 128'(a_acq_cnt), 128'(0));
        step();
        reset = 1'b1;
        step();
        chk("post_rst_acq_ready", 128'(a_acq_ir), 128'(1));

        // Eight-beat release burst with the outer side always ready
        rel_or = 1;
        for (int b = 0; b < 8; b++) begin
            rel_iv = 1;
            rel_ib = {3'(b), 26'h2AAAAAA, 2'd2, 1'b1, 3'd1, 16'(b * 16'h1111)};
            step();
            chk("thru_rel_count_le1", 128'(a_rel_cnt <= 2'd1), 128'(1));
        end
        rel_iv = 0;
        step();
        step();
        chk("thru_rel_drained", 128'(a_rel_cnt), 128'(0));

        // Backpressure on grant: the third beat stalls until the first dequeue
        gnt_or = 0;
        gnt_iv = 1;
        gnt_ib = {3'd0, 2'd1, 1'b0, 1'b1, 4'd5, 1'b1, 16'hA000};
        step();
        gnt_ib = {3'd1, 2'd1, 1'b0, 1'b1, 4'd5, 1'b1, 16'hA001};
        step();
        gnt_ib = {3'd2, 2'd1, 1'b0, 1'b1, 4'd5, 1'b1, 16'hA002};
        step();
        chk("gnt_stall_ready", 128'(a_gnt_ir), 128'(0));
        chk("gnt_full_count", 128'(a_gnt_cnt), 128'(2));
        gnt_or = 1;
        acc = 0;
        n = 0;
        while (!acc && n < 8) begin
            @(negedge clk);
            acc = a_gnt_ir;
            check_all();
            @(posedge clk);
            #1;
            n++;
        end
        chk("gnt_third_accept_cycle", 128'(n), 128'(2));
        gnt_iv = 0;
        for (int i = 0; i < 4; i++) step();
        chk("gnt_drained", 128'(a_gnt_cnt), 128'(0));

        // Flow-through bypass on an empty acquire queue
        acq_or = 1;
        step();
        step();
        acq_iv = 1;
        acq_ib = {26'h3ABCDEF, 2'd3, 3'd0, 1'b0, 3'd1, 12'h5A5, 16'hC0DE};
        #1;
        chk("flow_valid", 128'(b_acq_ov), 128'(1));
        chk("flow_bits", 128'(b_acq_ob), 128'(acq_ib));
        chk("flow_count", 128'(b_acq_cnt), 128'(0));
        step();
        chk("flow_count_after", 128'(b_acq_cnt), 128'(0));
        acq_iv = 0;
        step();

        // Random traffic on all channels
        for (int i = 0; i < 400; i++) begin
            acq_iv = ($urandom_range(0, 99) < 60);
            acq_or = ($urandom_range(0, 99) < 55);
            acq_ib = AW'({$urandom, $urandom});
            rel_iv = ($urandom_range(0, 99) < 60);
            rel_or = ($urandom_range(0, 99) < 45);
            rel_ib = RW'({$urandom, $urandom});
            gnt_iv = ($urandom_range(0, 99) < 60);
            gnt_or = ($urandom_range(0, 99) < 55);
            gnt_ib = GW'($urandom);
            prb_v  = 1'($urandom);
            prb_r  = 1'($urandom);
            prb_b  = 28'($urandom);
            fin_v  = 1'($urandom);
            fin_r  = 1'($urandom);
            fin_b  = 2'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
